// File: rtl/serial_port_ctrl.sv
// Byte-wide UART transceiver for one memory-mapped serial port (8N1).
// Define SERIAL_PARITY_EN to add an even-parity bit (8E1) on both directions.
module serial_port_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       writeData,
  input  logic [7:0] txByte,
  input  logic       readData,
  output logic [7:0] serialPortData,
  output logic [1:0] serialPortState
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BIT_LOAD  = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t HALF_LOAD = cnt_t'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef SERIAL_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rxState_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef SERIAL_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } txState_t;

  // ---------------- receiver ----------------
  logic       rxSync1, rxSync2, rxIn;
  rxState_t   rxState, rxStateNext;
  cnt_t       rxCnt, rxCntNext;
  logic [2:0] rxBit, rxBitNext;
  logic [7:0] rxShift, rxShiftNext;
  logic       rxDone;
  logic       rxReady;
`ifdef SERIAL_PARITY_EN
  logic       rxPar, rxParNext;
`endif

  assign rxIn = rxSync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxState <= RX_IDLE;
      rxCnt   <= '0;
      rxBit   <= '0;
      rxShift <= '0;
`ifdef SERIAL_PARITY_EN
      rxPar   <= 1'b0;
`endif
    end else begin
      rxSync1 <= rxd;
      rxSync2 <= rxSync1;
      rxState <= rxStateNext;
      rxCnt   <= rxCntNext;
      rxBit   <= rxBitNext;
      rxShift <= rxShiftNext;
`ifdef SERIAL_PARITY_EN
      rxPar   <= rxParNext;
`endif
    end
  end

  always_comb begin
    rxStateNext = rxState;
    rxCntNext   = rxCnt;
    rxBitNext   = rxBit;
    rxShiftNext = rxShift;
    rxDone      = 1'b0;
`ifdef SERIAL_PARITY_EN
    rxParNext   = rxPar;
`endif
    case (rxState)
      RX_IDLE: begin
        if (!rxIn) begin
          rxStateNext = RX_START;
          rxCntNext   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (rxCnt != '0) begin
          rxCntNext = rxCnt - cnt_t'(1);
        end else if (rxIn) begin
          rxStateNext = RX_IDLE;
        end else begin
          rxStateNext = RX_DATA;
          rxCntNext   = BIT_LOAD;
          rxBitNext   = '0;
        end
      end
      RX_DATA: begin
        if (rxCnt != '0) begin
          rxCntNext = rxCnt - cnt_t'(1);
        end else begin
          rxShiftNext = {rxIn, rxShift[7:1]};
          rxCntNext   = BIT_LOAD;
          if (rxBit == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            rxStateNext = RX_PARITY;
`else
            rxStateNext = RX_STOP;
`endif
          end else begin
            rxBitNext = rxBit + 3'd1;
          end
        end
      end
`ifdef SERIAL_PARITY_EN
      RX_PARITY: begin
        if (rxCnt != '0) begin
          rxCntNext = rxCnt - cnt_t'(1);
        end else begin
          rxParNext   = rxIn;
          rxCntNext   = BIT_LOAD;
          rxStateNext = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rxCnt != '0) begin
          rxCntNext = rxCnt - cnt_t'(1);
        end else begin
          rxStateNext = RX_IDLE;
`ifdef SERIAL_PARITY_EN
          rxDone = rxIn && (rxPar == ^rxShift);
`else
          rxDone = rxIn;
`endif
        end
      end
      default: rxStateNext = RX_IDLE;
    endcase
  end

  // A completing byte takes priority over a simultaneous read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serialPortData <= '0;
      rxReady        <= 1'b0;
    end else if (rxDone) begin
      serialPortData <= rxShift;
      rxReady        <= 1'b1;
    end else if (readData) begin
      rxReady        <= 1'b0;
    end
  end

  // ---------------- transmitter ----------------
  txState_t   txState, txStateNext;
  cnt_t       txCnt, txCntNext;
  logic [2:0] txBit, txBitNext;
  logic [7:0] txShift, txShiftNext;
  logic       txdNext;
`ifdef SERIAL_PARITY_EN
  logic       txPar, txParNext;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState <= TX_IDLE;
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
      txd     <= 1'b1;
`ifdef SERIAL_PARITY_EN
      txPar   <= 1'b0;
`endif
    end else begin
      txState <= txStateNext;
      txCnt   <= txCntNext;
      txBit   <= txBitNext;
      txShift <= txShiftNext;
      txd     <= txdNext;
`ifdef SERIAL_PARITY_EN
      txPar   <= txParNext;
`endif
    end
  end

  // txd is computed one bit ahead and registered, so it changes only on bit boundaries.
  always_comb begin
    txStateNext = txState;
    txCntNext   = txCnt;
    txBitNext   = txBit;
    txShiftNext = txShift;
    txdNext     = txd;
`ifdef SERIAL_PARITY_EN
    txParNext   = txPar;
`endif
    case (txState)
      TX_IDLE: begin
        txdNext = 1'b1;
        if (writeData) begin
          txStateNext = TX_START;
          txCntNext   = BIT_LOAD;
          txShiftNext = txByte;
          txdNext     = 1'b0;
`ifdef SERIAL_PARITY_EN
          txParNext   = ^txByte;
`endif
        end
      end
      TX_START: begin
        if (txCnt != '0) begin
          txCntNext = txCnt - cnt_t'(1);
        end else begin
          txStateNext = TX_DATA;
          txCntNext   = BIT_LOAD;
          txBitNext   = '0;
          txdNext     = txShift[0];
          txShiftNext = {1'b0, txShift[7:1]};
        end
      end
      TX_DATA: begin
        if (txCnt != '0) begin
          txCntNext = txCnt - cnt_t'(1);
        end else begin
          txCntNext = BIT_LOAD;
          if (txBit == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            txStateNext = TX_PARITY;
            txdNext     = txPar;
`else
            txStateNext = TX_STOP;
            txdNext     = 1'b1;
`endif
          end else begin
            txBitNext   = txBit + 3'd1;
            txdNext     = txShift[0];
            txShiftNext = {1'b0, txShift[7:1]};
          end
        end
      end
`ifdef SERIAL_PARITY_EN
      TX_PARITY: begin
        if (txCnt != '0) begin
          txCntNext = txCnt - cnt_t'(1);
        end else begin
          txStateNext = TX_STOP;
          txCntNext   = BIT_LOAD;
          txdNext     = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (txCnt != '0) begin
          txCntNext = txCnt - cnt_t'(1);
        end else begin
          txStateNext = TX_IDLE;
        end
      end
      default: begin
        txStateNext = TX_IDLE;
        txdNext     = 1'b1;
      end
    endcase
  end

  assign serialPortState = {rxReady, (txState == TX_IDLE)};

endmodule

// File: tb/tb_serial_port_ctrl.sv
// Self-checking bench for serial_port_ctrl: frame-level reference model plus directed literal checks.
module tb_serial_port_ctrl;
  localparam int N    = 4;
  localparam int HALF = N / 2;
`ifdef SERIAL_PARITY_EN
  localparam int FB   = 11;
`else
  localparam int FB   = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       writeData = 1'b0;
  logic [7:0] txByte = 8'h00;
  logic       readData = 1'b0;
  logic       txd;
  logic [7:0] serialPortData;
  logic [1:0] serialPortState;

  serial_port_ctrl #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
    .writeData(writeData), .txByte(txByte), .readData(readData),
    .serialPortData(serialPortData), .serialPortState(serialPortState)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chkEn = 1'b0;

  // Reference model: frame timing from bit-time arithmetic, not from any state machine.
  int          txLeft = 0;
  logic [10:0] txFrame = '1;
  logic [7:0]  mData = 8'h00;
  logic        mRdy = 1'b0;
  typedef struct { int at; logic [7:0] b; bit ok; } rxEv_t;
  rxEv_t rxQ[$];
  rxEv_t ev;
  bit    doneNow;

  // Bit 0 start, bits 1..8 data LSB first, then optional parity, then stop.
  function automatic logic [10:0] mkFrame(input logic [7:0] b, input logic par, input logic stop);
`ifdef SERIAL_PARITY_EN
    return {stop, par, b, 1'b0};
`else
    return {1'b1, stop ^ (par & 1'b0), b, 1'b0};
`endif
  endfunction

  always begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      txLeft = 0;
      mData  = 8'h00;
      mRdy   = 1'b0;
      rxQ.delete();
    end else begin
      cyc++;
      doneNow = 1'b0;
      if (rxQ.size() > 0 && rxQ[0].at == cyc) begin
        ev = rxQ.pop_front();
        doneNow = ev.ok;
        if (ev.ok) mData = ev.b;
      end
      if (doneNow) mRdy = 1'b1;
      else if (readData) mRdy = 1'b0;
      if (txLeft == 0) begin
        if (writeData) begin
          txFrame = mkFrame(txByte, ^txByte, 1'b1);
          txLeft  = FB * N;
        end
      end else begin
        txLeft--;
      end
    end
  end

  function automatic logic expTxd();
    if (txLeft > 0) return txFrame[(FB * N - txLeft) / N];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      check("txd", {15'd0, txd}, {15'd0, expTxd()});
      check("txReady", {15'd0, serialPortState[0]}, {15'd0, txLeft == 0});
      check("rxReady", {15'd0, serialPortState[1]}, {15'd0, mRdy});
      check("rxData", {8'd0, serialPortData}, {8'd0, mData});
    end
  end

  // All stimulus tasks are entered just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendTx(input logic [7:0] b);
    txByte = b;
    writeData = 1'b1;
    @(negedge clk);
    writeData = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] b, input logic par, input logic stop);
    logic [10:0] f;
    rxEv_t e;
    f = mkFrame(b, par, stop);
    e.at = cyc + 1 + 2 + HALF + (FB - 1) * N;
    e.b  = b;
`ifdef SERIAL_PARITY_EN
    e.ok = stop && (par == ^b);
`else
    e.ok = stop;
`endif
    rxQ.push_back(e);
    for (int i = 0; i < FB; i++) begin
      rxd = f[i];
      repeat (N) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic pulseReadAt(input int edgeNum);
    for (int g = 0; g < 2000 && cyc < edgeNum - 1; g++) @(negedge clk);
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
  endtask

  // Transmit one byte, recording txd at mid-bit and the number of busy cycles.
  task automatic runTx(input logic [7:0] b, input bit extraWrite,
                       output int busy, output logic [10:0] seq);
    busy = 0;
    seq  = '0;
    sendTx(b);
    for (int j = 0; j < FB * N + 8; j++) begin
      if (!serialPortState[0]) busy++;
      if (j < FB * N && (j % N) == 2) seq[j / N] = txd;
      if (extraWrite && j == 9) begin txByte = 8'hFF; writeData = 1'b1; end
      if (j == 10) writeData = 1'b0;
      @(negedge clk);
    end
  endtask

  int          busy;
  int          doneEdge;
  logic [10:0] seq;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_txd", {15'd0, txd}, 16'h1);
    check("rst_state", {14'd0, serialPortState}, 16'h1);
    check("rst_data", {8'd0, serialPortData}, 16'h0);
    rst = 1'b1;
    chkEn = 1'b1;
    tick(2);

    runTx(8'hA5, 1'b1, busy, seq);
`ifdef SERIAL_PARITY_EN
    check("tx_a5_seq", {6'd0, seq[9:0]}, {6'd0, 10'b0101001010});
    check("tx_a5_busy", busy[15:0], 16'd44);
`else
    check("tx_a5_seq", {6'd0, seq[9:0]}, {6'd0, 10'b1101001010});
    check("tx_a5_busy", busy[15:0], 16'd40);
`endif

    sendRx(8'h3C, ^8'h3C, 1'b1);
    tick(6);
    check("rx_3c_data", {8'd0, serialPortData}, 16'h3C);
    check("rx_3c_state", {14'd0, serialPortState}, 16'h3);
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    check("rd_state", {14'd0, serialPortState}, 16'h1);
    check("rd_data", {8'd0, serialPortData}, 16'h3C);

    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(12);
    check("glitch_state", {14'd0, serialPortState}, 16'h1);

    sendRx(8'hFF, ^8'hFF, 1'b0);
    tick(12);
    check("frame_err_data", {8'd0, serialPortData}, 16'h3C);
    check("frame_err_state", {14'd0, serialPortState}, 16'h1);

    sendRx(8'h11, ^8'h11, 1'b1);
    tick(4);
    sendRx(8'h22, ^8'h22, 1'b1);
    tick(6);
    check("overrun_data", {8'd0, serialPortData}, 16'h22);
    check("overrun_rdy", {15'd0, serialPortState[1]}, 16'h1);

    doneEdge = cyc + 1 + 2 + HALF + (FB - 1) * N;
    fork
      sendRx(8'h33, ^8'h33, 1'b1);
      pulseReadAt(doneEdge);
    join
    tick(4);
    check("collide_data", {8'd0, serialPortData}, 16'h33);
    check("collide_rdy", {15'd0, serialPortState[1]}, 16'h1);
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    tick(2);

`ifdef SERIAL_PARITY_EN
    runTx(8'h07, 1'b0, busy, seq);
    check("par_tx_bit", {15'd0, seq[9]}, 16'h1);
    check("par_tx_busy", busy[15:0], 16'd44);
    sendRx(8'h07, 1'b0, 1'b1);
    tick(12);
    check("par_bad_data", {8'd0, serialPortData}, 16'h33);
    check("par_bad_rdy", {15'd0, serialPortState[1]}, 16'h0);
    sendRx(8'h07, 1'b1, 1'b1);
    tick(6);
    check("par_ok_data", {8'd0, serialPortData}, 16'h07);
    check("par_ok_rdy", {15'd0, serialPortState[1]}, 16'h1);
`endif

    // Asynchronous reset in the middle of a transmit frame.
    sendTx(8'hC3);
    tick(10);
    #2;
    rst = 1'b0;
    #1;
    check("arst_txd", {15'd0, txd}, 16'h1);
    check("arst_state", {14'd0, serialPortState}, 16'h1);
    check("arst_data", {8'd0, serialPortData}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    runTx(8'h55, 1'b0, busy, seq);
`ifdef SERIAL_PARITY_EN
    check("post_rst_seq", {6'd0, seq[9:0]}, {6'd0, 10'b0010101010});
`else
    check("post_rst_seq", {6'd0, seq[9:0]}, {6'd0, 10'b1010101010});
`endif
    tick(4);

    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
